// File: rtl/warp_addr_arbiter_pkg.sv
// Shared tau-core configuration constants used by the address-stream blocks.
package TauCfg;
  localparam int VSIZE          = 4;   // address lanes per beat
  localparam int GLOBAL_ADDR_BW = 16;  // width of one lane address
  localparam int N_ICFG         = 4;   // number of configuration ids
endpackage

// File: rtl/warp_addr_arbiter_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module RoundRobinPick #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Walk offsets from farthest to nearest so the nearest request to ptr wins.
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IW'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/warp_addr_arbiter.sv
// Packet-locked round-robin arbiter merging N_SRC address streams into one
// registered output slot. A requester keeps the grant until its retire beat.
module warp_addr_arbiter
  import TauCfg::*;
#(
  parameter  int N_SRC   = 2,
  parameter  int N_CFG   = N_ICFG,
  parameter  int ABW     = GLOBAL_ADDR_BW,
  localparam int NCFG_BW = (N_CFG > 1) ? $clog2(N_CFG) : 1,
  localparam int SRC_BW  = $clog2(N_SRC)
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic [N_SRC-1:0]                      src_rdy,
  output logic [N_SRC-1:0]                      src_ack,
  input  logic [N_SRC-1:0][NCFG_BW-1:0]         i_id,
  input  logic [N_SRC-1:0][VSIZE-1:0][ABW-1:0]  i_address,
  input  logic [N_SRC-1:0][VSIZE-1:0]           i_valid,
  input  logic [N_SRC-1:0]                      i_retire,
  output logic                                  dst_rdy,
  input  logic                                  dst_ack,
  output logic [NCFG_BW-1:0]                    o_id,
  output logic [VSIZE-1:0][ABW-1:0]             o_address,
  output logic [VSIZE-1:0]                      o_valid,
  output logic                                  o_retire,
  output logic [SRC_BW-1:0]                     o_src
);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t              state, state_n;
  logic [SRC_BW-1:0]   ptr, ptr_n;
  logic [SRC_BW-1:0]   gnt, gnt_n;
  logic                full;
  logic [N_SRC-1:0]    pick_oh;
  logic [SRC_BW-1:0]   pick_idx;
  logic                pick_any;
  logic                can_load;
  logic                load;
  logic [SRC_BW-1:0]   sel;

  function automatic logic [SRC_BW-1:0] wrap_inc(input logic [SRC_BW-1:0] x);
    return (int'(x) == N_SRC - 1) ? '0 : x + SRC_BW'(1);
  endfunction

  RoundRobinPick #(.N(N_SRC)) u_pick (
    .req (src_rdy),
    .ptr (ptr),
    .gnt (pick_oh),
    .idx (pick_idx),
    .any (pick_any)
  );

  // The slot takes a new beat when empty or when it drains in the same cycle.
  assign can_load = !full || dst_ack;
  assign sel      = (state == IDLE) ? pick_idx : gnt;
  assign load     = |src_ack;
  assign dst_rdy  = full;

  // Output decode: round-robin grant when idle, only the owner while locked.
  always_comb begin
    src_ack = '0;
    if (!i_rst && can_load) begin
      if (state == IDLE) begin
        src_ack = pick_any ? pick_oh : '0;
      end else begin
        src_ack[gnt] = src_rdy[gnt];
      end
    end
  end

  // Next-state: lock on a non-retiring beat, release and advance ptr on retire.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = gnt;
    if (load) begin
      if (state == IDLE) begin
        if (i_retire[sel]) begin
          ptr_n = wrap_inc(sel);
        end else begin
          state_n = LOCK;
          gnt_n   = sel;
        end
      end else if (i_retire[gnt]) begin
        state_n = IDLE;
        ptr_n   = wrap_inc(gnt);
      end
    end
  end

  // State register plus the single output slot and its full flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      full      <= 1'b0;
      o_id      <= '0;
      o_address <= '0;
      o_valid   <= '0;
      o_retire  <= 1'b0;
      o_src     <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      gnt   <= gnt_n;
      if (load) begin
        full      <= 1'b1;
        o_id      <= i_id[sel];
        o_address <= i_address[sel];
        o_valid   <= i_valid[sel];
        o_retire  <= i_retire[sel];
        o_src     <= sel;
      end else if (dst_ack) begin
        full <= 1'b0;
      end
    end
  end

endmodule
